// File: rtl/rr_arb_pkg.sv
// Shared arbiter helpers: index width and one-hot to index.
package rr_arb_pkg;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [4:0] oh2idx(input logic [31:0] oh);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) r = r | 5'(i);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_param_pick.sv
// Round-robin winner select: rotate req by ptr, take the lowest set bit,
// rotate the one-hot back.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win_oh,
  output logic [IDW-1:0] win_idx,
  output logic           any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_oh;

  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[N-1:0];
    rot_oh  = rot & (~rot + N'(1));
    back    = {rot_oh, rot_oh} << ptr;
    win_oh  = back[2*N-1:N];
    win_idx = IDW'(oh2idx(32'(win_oh)));
    any     = |req;
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter with per-burst hold limit and
// registered one-hot / binary grant.
module rr_arbiter_param
  import rr_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = idw(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_idx;
  logic           any;
  logic           keep;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  // hold_cnt never exceeds MAX_HOLD-1, so != is the same as <
  assign keep = grant_valid && |(req & grant) &&
                (hold_cnt != HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else if (keep) begin
      hold_cnt <= hold_cnt + HW'(1);
    end else if (any) begin
      grant       <= win_oh;
      grant_id    <= win_idx;
      grant_valid <= 1'b1;
      hold_cnt    <= '0;
      ptr         <= (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
    end else begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Scoreboard bench for rr_arbiter_param: directed vectors on three
// N=4 configurations plus a random N=8 invariant/starvation run.
module tb_rr_arbiter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req1, req3, req4;
  logic [7:0] req8;
  logic [3:0] g1, g3, g4;
  logic [1:0] id1, id3, id4;
  logic       v1, v3, v4;
  logic [7:0] g8;
  logic [2:0] id8;
  logic       v8;

  rr_arbiter_param #(.N(4), .MAX_HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .grant(g1), .grant_id(id1), .grant_valid(v1));

  rr_arbiter_param #(.N(4), .MAX_HOLD(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req3),
    .grant(g3), .grant_id(id3), .grant_valid(v3));

  rr_arbiter_param #(.N(4), .MAX_HOLD(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4),
    .grant(g4), .grant_id(id4), .grant_valid(v4));

  rr_arbiter_param #(.N(8), .MAX_HOLD(2)) u8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
    .grant(g8), .grant_id(id8), .grant_valid(v8));

  typedef struct {
    int         dut;
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    int         hold;
    int         tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input int tag,
                     input logic [7:0] ag, input logic [7:0] eg,
                     input logic [2:0] aid, input logic [2:0] eid,
                     input logic av, input logic ev,
                     input int ah, input int eh);
    n_cmp++;
    if (ag !== eg || aid !== eid || av !== ev ||
        (eh >= 0 && ah != eh)) begin
      n_bad++;
      $display("FAIL vec%0d: got grant=%b id=%0d valid=%b hold=%0d, want grant=%b id=%0d valid=%b hold=%0d",
               tag, ag, aid, av, ah, eg, eid, ev, eh);
    end
  endtask

  task automatic push(input int dut, input logic [7:0] g,
                      input int id, input int hold, input int tag);
    exp_t x;
    x.dut = dut; x.g = g; x.id = 3'(id); x.v = |g;
    x.hold = hold; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic step(input int dut, input logic [7:0] r,
                      input logic [7:0] g, input int id,
                      input int hold, input int tag);
    @(negedge clk);
    case (dut)
      1: req1 = r[3:0];
      3: req3 = r[3:0];
      4: req4 = r[3:0];
      default: req8 = r;
    endcase
    push(dut, g, id, hold, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req1 = '0; req3 = '0; req4 = '0; req8 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare the DUT named by each expectation after every edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.dut)
        1: chk(e.tag, {4'b0, g1}, e.g, {1'b0, id1}, e.id, v1, e.v,
               int'(u1.hold_cnt), e.hold);
        3: chk(e.tag, {4'b0, g3}, e.g, {1'b0, id3}, e.id, v3, e.v,
               int'(u3.hold_cnt), e.hold);
        4: chk(e.tag, {4'b0, g4}, e.g, {1'b0, id4}, e.id, v4, e.v,
               int'(u4.hold_cnt), e.hold);
        default: chk(e.tag, g8, e.g, id8, e.id, v8, e.v,
                     int'(u8.hold_cnt), e.hold);
      endcase
    end
  end

  logic [7:0] rs;
  int         wait_c[8];
  int         exp_idx;
  logic       ok;

  initial begin
    rst_n = 1'b0;
    req1 = '0; req3 = '0; req4 = '0; req8 = '0;
    #3;
    chk(0, {4'b0, g1}, 8'h00, {1'b0, id1}, 3'd0, v1, 1'b0,
        int'(u1.hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle after release
    step(1, 8'h0, 8'h0, 0, 0, 1);
    step(1, 8'h0, 8'h0, 0, 0, 2);

    // MAX_HOLD=1, all requesting: plain rotation
    step(1, 8'hf, 8'h1, 0, 0, 10);
    step(1, 8'hf, 8'h2, 1, 0, 11);
    step(1, 8'hf, 8'h4, 2, 0, 12);
    step(1, 8'hf, 8'h8, 3, 0, 13);
    step(1, 8'hf, 8'h1, 0, 0, 14);

    // MAX_HOLD=1: ptr moves to 2 after granting requester 1
    do_reset();
    step(1, 8'h2, 8'h2, 1, 0, 20);
    step(1, 8'h9, 8'h8, 3, 0, 21);
    step(1, 8'h9, 8'h1, 0, 0, 22);
    step(1, 8'h9, 8'h8, 3, 0, 23);

    // MAX_HOLD=3 bursts
    do_reset();
    step(3, 8'h5, 8'h1, 0, 0, 30);
    step(3, 8'h5, 8'h1, 0, 1, 31);
    step(3, 8'h5, 8'h1, 0, 2, 32);
    step(3, 8'h5, 8'h4, 2, 0, 33);
    step(3, 8'h5, 8'h4, 2, 1, 34);
    step(3, 8'h5, 8'h4, 2, 2, 35);
    step(3, 8'h5, 8'h1, 0, 0, 36);
    step(3, 8'h0, 8'h0, 0, 0, 37);
    // sole requester re-granted on hold expiry
    step(3, 8'h1, 8'h1, 0, 0, 38);
    step(3, 8'h1, 8'h1, 0, 1, 39);
    step(3, 8'h1, 8'h1, 0, 2, 40);
    step(3, 8'h1, 8'h1, 0, 0, 41);

    // reset mid-burst clears at once; burst is not resumed
    do_reset();
    step(3, 8'h5, 8'h1, 0, 0, 50);
    step(3, 8'h5, 8'h1, 0, 1, 51);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(52, {4'b0, g3}, 8'h00, {1'b0, id3}, 3'd0, v3, 1'b0,
        int'(u3.hold_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push(3, 8'h1, 0, 0, 53);
    step(3, 8'h5, 8'h1, 0, 1, 54);

    // MAX_HOLD=4: requester 1 drops mid-burst, no idle bubble
    do_reset();
    step(4, 8'h6, 8'h2, 1, 0, 60);
    step(4, 8'h6, 8'h2, 1, 1, 61);
    step(4, 8'h4, 8'h4, 2, 0, 62);
    step(4, 8'h4, 8'h4, 2, 1, 63);

    do_reset();
    @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    // N=8 random: invariants and bounded wait (7 * 2 = 14 cycles)
    for (int b = 0; b < 8; b++) wait_c[b] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++)
        if ($urandom_range(7) == 0) req8[b] = ~req8[b];
      rs = req8;
      @(posedge clk);
      #1;
      exp_idx = 0;
      for (int b = 0; b < 8; b++) if (g8[b]) exp_idx = b;
      ok = $onehot0(g8) && (v8 == |g8) && ((g8 & ~rs) == 8'h0) &&
           (v8 == |rs) && (id8 == 3'(exp_idx));
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rand_inv c%0d: got grant=%b id=%0d valid=%b, req=%b",
                 c, g8, id8, v8, rs);
      end
      for (int b = 0; b < 8; b++) begin
        if (rs[b] && !g8[b]) wait_c[b]++;
        else wait_c[b] = 0;
        if (wait_c[b] > 14) begin
          n_cmp++;
          n_bad++;
          $display("FAIL starve c%0d: req%0d waited %0d cycles, want <= 14",
                   c, b, wait_c[b]);
          wait_c[b] = 0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_param.md
# rr_arbiter_param

Parametrised round-robin arbiter with burst hold, generalising the team's fixed 4-requester arbiter to N requesters. A granted requester may keep the grant for up to MAX_HOLD consecutive cycles while its request stays asserted. The grant is registered and returned as one-hot, as binary ID and with a valid flag. It sits in front of any shared resource (bus, memory port, FIFO write side) with N independent clients.

## Interface
- N, default 4: number of requesters, 2..32.
- MAX_HOLD, default 4: maximum consecutive grant cycles per burst, ≥1.
- IDW, derived: $clog2(N), width of grant_id.

- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  registered one-hot grant; all zero when idle.
- grant_id  output  IDW  binary index of the granted requester; 0 when idle.
- grant_valid  output  1  high iff grant is non-zero.

## Operation
- State: ptr (IDW bits, highest-priority index), cur (current grant), hold_cnt (counts 0..MAX_HOLD-1).
- Keep condition, evaluated each posedge: grant_valid and req[grant_id] high and hold_cnt < MAX_HOLD-1.
  - Result: grant unchanged; hold_cnt increments.
- Otherwise, arbitrate:
  - Scan req starting at ptr, then ascending modulo N; the first set bit i wins.
  - Set grant to one-hot bit i, grant_id to i, hold_cnt to 0, ptr to (i+1) mod N.
- No request set during arbitration: grant becomes 0, grant_valid 0, ptr unchanged, hold_cnt 0.
- Hold expiry with only the same requester active: that requester is re-granted. grant_valid stays high, hold_cnt restarts at 0, ptr is set to (i+1) mod N again.
- Requests arriving during a hold wait until the hold ends. No starvation: each active requester is granted within (N-1)·MAX_HOLD cycles.
- Requester drops req mid-burst: grant moves to the next winner at the following posedge. There is no idle bubble if another request is pending.
- req bits are sampled only at posedge. Glitches between edges have no effect.
- Invariants: grant is always one-hot or zero; grant_id == index of the set bit in grant; grant_valid == |grant.

## Timing
- Latency: req sampled at edge k gives grant at edge k, visible after clock-to-q. Observed one cycle after req is driven at the preceding negedge.
- Outputs come directly from flops. There is no combinational path from req to any output.
- Reset (rst_n low, asynchronous, no clock needed):
  - grant=0, grant_id=0, grant_valid=0.
  - ptr=0, so requester 0 has first priority after reset.
  - hold_cnt=0.
- Reset release: the first arbitration happens at the first posedge with rst_n high.
- Reset asserted mid-burst: all state clears immediately; the burst is abandoned and not resumed.

## Structure
- Package rr_arb_pkg: the function computing IDW, plus the one-hot-to-index conversion function, shared with other arbiters in the codebase.
- Sub-module rr_pick (combinational): inputs req and ptr; outputs the winner one-hot, the winner index and the any-request flag. Implement as a double-width rotate plus priority encode.
- The top level holds ptr, hold_cnt and the grant registers, plus the keep/arbitrate decision.

## Test plan
- Reset: drive rst_n=0 mid-simulation with no clock edge → grant=0000, grant_id=0, grant_valid=0 immediately; after release with req=0000 the outputs stay idle.
- N=4, MAX_HOLD=1, req=1111 held → grants 0001, 0010, 0100, 1000, 0001 on successive cycles; grant_id 0,1,2,3,0.
- N=4, MAX_HOLD=1: req=0010 for one cycle, then 1001 for three cycles → grant 0010, then 1000, then 0001, then 1000 (ptr starts at 2 after the first grant).
- N=4, MAX_HOLD=3, req=0101 held → grant 0001 for 3 cycles, 0100 for 3 cycles, then 0001 again; hold_cnt observed 0,1,2.
- N=4, MAX_HOLD=4, req=0110, then req[1] dropped after 2 grant cycles → grant 0010 for 2 cycles, then 0100 with no idle cycle.
- N=8, MAX_HOLD=2, random req for 10k cycles → one-hot/ID/valid invariants hold; every requester held continuously high is granted within 14 cycles.
